des_key_schedule: RTL and testbench

- DES subkey generator that sits beside the round datapath and is sequenced by the DES control FSM.
- On `load` it performs PC-1 (parity drop, 64→56 bits) into C/D halves.
- On each `next` request it rotates C/D and compresses them through PC-2, producing one 48-bit round subkey.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

---
 rtl/des_key_schedule.sv | 197 +++++++++++++++++++
 tb/tb_des_key_schedule.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES round-subkey generator, sequenced by the DES control FSM.
// A load pulse latches the key and the direction, then PC-1 splits it into the
// 28-bit C/D halves. Each accepted next rotates C/D and compresses them through
// PC-2 into one 48-bit subkey, in K1..K16 order or, for decrypt, K16..K1.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   key_in       64-bit DES key, key_in[63] is DES bit 1; parity bits ignored
//   load         pulse: latch key_in/decrypt and restart the schedule
//   decrypt      0 = K1..K16, 1 = K16..K1; sampled only with load
//   next         request the next subkey; honoured only while idle in WAIT
//   subkey       current subkey, subkey[47] is PC-2 output bit 1
//   subkey_valid high from subkey update until the next accepted next/load
//   round_idx    subkeys produced since load (0..16)
//   busy         high while in PC1, ROT or PC2
//   done         high in WAIT once all 16 subkeys have been produced
module des_key_schedule (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] key_in,
    input  logic        load,
    input  logic        decrypt,
    input  logic        next,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [4:0]  round_idx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ROUNDS = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PC1  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ROT  = 3'd3;
    localparam logic [2:0] S_PC2  = 3'd4;

    // Tables hold 1-based DES bit numbers, bit 1 being the MSB.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            r[6'(55 - j)] = k[6'(64 - PC1_TAB[6'(j)])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[6'(47 - j)] = cd[6'(56 - PC2_TAB[6'(j)])];
        end
        return r;
    endfunction

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [63:0] key_reg;
    logic        mode;
    logic [27:0] c_reg;
    logic [27:0] d_reg;

    logic        accept_next_c;
    logic [4:0]  n_c;
    logic [4:0]  table_r_c;
    logic        shift_one_c;
    logic        no_rot_c;
    logic [27:0] c_rot_c;
    logic [27:0] d_rot_c;
    logic [55:0] pc1_c;

    // Next-state logic; load restarts the schedule from any state.
    always_comb begin
        state_nx      = state;
        accept_next_c = 1'b0;
        case (state)
            S_IDLE: state_nx = state;
            S_PC1:  state_nx = S_WAIT;
            S_WAIT: begin
                if (next && (round_idx != 5'(ROUNDS))) begin
                    accept_next_c = !load;
                    state_nx      = S_ROT;
                end
            end
            S_ROT:  state_nx = S_PC2;
            S_PC2:  state_nx = S_WAIT;
            default: state_nx = S_IDLE;
        endcase
        if (load) begin
            state_nx = S_PC1;
        end
    end

    // Rotation for round n; decrypt walks the shift table backwards, starting
    // from the post-PC-1 value (cumulative 28) which already equals K16's C/D.
    always_comb begin
        n_c         = round_idx + 5'd1;
        table_r_c   = mode ? 5'(5'd18 - n_c) : n_c;
        shift_one_c = (table_r_c == 5'd1) || (table_r_c == 5'd2) ||
                      (table_r_c == 5'd9) || (table_r_c == 5'd16);
        no_rot_c    = mode && (n_c == 5'd1);
        pc1_c       = pc1(key_reg);
        c_rot_c     = c_reg;
        d_rot_c     = d_reg;
        if (!no_rot_c) begin
            if (!mode) begin
                c_rot_c = shift_one_c ? {c_reg[26:0], c_reg[27]}    : {c_reg[25:0], c_reg[27:26]};
                d_rot_c = shift_one_c ? {d_reg[26:0], d_reg[27]}    : {d_reg[25:0], d_reg[27:26]};
            end else begin
                c_rot_c = shift_one_c ? {c_reg[0], c_reg[27:1]}     : {c_reg[1:0], c_reg[27:2]};
                d_rot_c = shift_one_c ? {d_reg[0], d_reg[27:1]}     : {d_reg[1:0], d_reg[27:2]};
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_reg      <= '0;
            mode         <= 1'b0;
            c_reg        <= '0;
            d_reg        <= '0;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            round_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy <= (state_nx == S_PC1) || (state_nx == S_ROT) || (state_nx == S_PC2);
            done <= (state_nx == S_WAIT) && (round_idx == 5'(ROUNDS));
            if (load) begin
                key_reg      <= key_in;
                mode         <= decrypt;
                round_idx    <= '0;
                subkey_valid <= 1'b0;
            end else begin
                case (state)
                    S_PC1: begin
                        c_reg     <= pc1_c[55:28];
                        d_reg     <= pc1_c[27:0];
                        round_idx <= '0;
                    end
                    S_WAIT: begin
                        if (accept_next_c) begin
                            subkey_valid <= 1'b0;
                        end
                    end
                    S_ROT: begin
                        c_reg     <= c_rot_c;
                        d_reg     <= d_rot_c;
                        round_idx <= n_c;
                    end
                    S_PC2: begin
                        subkey       <= pc2({c_reg, d_reg});
                        subkey_valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus pushes the expected
// subkey/round for each accepted request; a monitor pops on each rising
// subkey_valid and compares. Directed checks cover reset, done and aborts.
module tb_des_key_schedule;

    logic        clk;
    logic        reset;
    logic [63:0] key_in;
    logic        load;
    logic        decrypt;
    logic        next;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [4:0]  round_idx;
    logic        busy;
    logic        done;

    des_key_schedule dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .load         (load),
        .decrypt      (decrypt),
        .next         (next),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] sub;
        logic [4:0]  rnd;
    } exp_t;

    exp_t exp_q [$];
    int   checks;
    int   failures;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [47:0] KB1   = 48'hFFFFFFFFFFFF;

    // Subkeys K1..K16 of KEY_A.
    localparam logic [47:0] KA [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [47:0] s, input logic [4:0] r);
        exp_t e;
        e.sub = s;
        e.rnd = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic do_load(input logic [63:0] k, input logic dec);
        key_in  = k;
        decrypt = dec;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        tick();
    endtask

    task automatic req_next(input logic [47:0] s, input logic [4:0] r);
        push_exp(s, r);
        next = 1'b1;
        tick();
        next = 1'b0;
        wait_idle("busy_timeout");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        key_in   = KEY_A;
        load     = 1'b1;
        decrypt  = 1'b0;
        next     = 1'b1;

        fork
            begin : monitor
                logic prev;
                exp_t e;
                prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (subkey_valid === 1'b1 && !prev) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_subkey", 64'(subkey), 64'(48'h0));
                            check("unexpected_valid", 64'(subkey_valid), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("subkey", 64'(subkey), 64'(e.sub));
                            check("round_idx", 64'(round_idx), 64'(e.rnd));
                        end
                    end
                    prev = (subkey_valid === 1'b1);
                end
            end
            begin : stimulus
                // Reset dominates load and next.
                tick();
                tick();
                check("rst_subkey", 64'(subkey), 64'd0);
                check("rst_valid", 64'(subkey_valid), 64'd0);
                check("rst_round", 64'(round_idx), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                load  = 1'b0;
                next  = 1'b0;
                reset = 1'b1;
                tick();
                check("rst_busy_after", 64'(busy), 64'd0);

                // next is ignored in IDLE.
                next = 1'b1;
                tick();
                next = 1'b0;
                tick();
                check("idle_next_busy", 64'(busy), 64'd0);
                check("idle_next_valid", 64'(subkey_valid), 64'd0);

                // Full encrypt run; decrypt toggled after load must not matter.
                do_load(KEY_A, 1'b0);
                check("load_wait_busy", 64'(busy), 64'd0);
                check("load_round", 64'(round_idx), 64'd0);
                decrypt = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    req_next(KA[i], 5'(i + 1));
                    if (i == 0) check("enc_done_early", 64'(done), 64'd0);
                end
                check("enc_done", 64'(done), 64'd1);
                check("enc_round16", 64'(round_idx), 64'd16);
                // 17th request ignored.
                next = 1'b1;
                tick();
                next = 1'b0;
                tick();
                tick();
                check("n17_round", 64'(round_idx), 64'd16);
                check("n17_subkey", 64'(subkey), 64'(KA[15]));
                check("n17_done", 64'(done), 64'd1);
                check("n17_valid", 64'(subkey_valid), 64'd1);
                check("n17_busy", 64'(busy), 64'd0);

                // Decrypt run: reversed order.
                do_load(KEY_A, 1'b1);
                decrypt = 1'b0;
                check("dec_valid_cleared", 64'(subkey_valid), 64'd0);
                check("dec_done_cleared", 64'(done), 64'd0);
                for (int i = 0; i < 16; i++) begin
                    req_next(KA[15 - i], 5'(i + 1));
                end
                check("dec_done", 64'(done), 64'd1);

                // next held through ROT and PC2 yields a single subkey.
                do_load(KEY_A, 1'b0);
                push_exp(KA[0], 5'd1);
                next = 1'b1;
                tick();
                tick();
                tick();
                next = 1'b0;
                tick();
                tick();
                check("stray_round", 64'(round_idx), 64'd1);
                req_next(KA[1], 5'd2);

                // load and next together in WAIT: load wins.
                load = 1'b1;
                next = 1'b1;
                tick();
                load = 1'b0;
                next = 1'b0;
                check("lw_round", 64'(round_idx), 64'd0);
                check("lw_valid", 64'(subkey_valid), 64'd0);
                check("lw_busy", 64'(busy), 64'd1);
                tick();
                req_next(KA[0], 5'd1);

                // Abort at round 7 during ROT with a new key.
                do_load(KEY_A, 1'b0);
                for (int i = 0; i < 6; i++) begin
                    req_next(KA[i], 5'(i + 1));
                end
                next = 1'b1;
                tick();
                next   = 1'b0;
                key_in = KEY_B;
                load   = 1'b1;
                tick();
                load   = 1'b0;
                check("abort_round", 64'(round_idx), 64'd0);
                check("abort_valid", 64'(subkey_valid), 64'd0);
                tick();
                req_next(KB1, 5'd1);
                check("abort_done", 64'(done), 64'd0);

                // Reset mid-operation.
                next = 1'b1;
                tick();
                next  = 1'b0;
                reset = 1'b0;
                tick();
                check("midrst_subkey", 64'(subkey), 64'd0);
                check("midrst_round", 64'(round_idx), 64'd0);
                check("midrst_busy", 64'(busy), 64'd0);
                reset = 1'b1;
                tick();
                tick();
                check("midrst_idle_busy", 64'(busy), 64'd0);
                check("queue_empty", 64'(exp_q.size()), 64'd0);
            end
        join_any

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
